// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, framer state encoding and frame-length helper.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

    // Frame length in bit times; multiply by CLKS_PER_BIT for cycles.
    function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + (parity != PAR_NONE ? 1 : 0) + stop_bits;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered full/empty flags and a level count.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level_next;
    logic             push, pop;

    always_comb begin
        push = wr_en && !full;
        pop = rd_en && !empty;
        level_next = push && !pop ? level + 1'b1 : pop && !push ? level - 1'b1 : level;
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full <= level_next == (AW+1)'(DEPTH);
            empty <= level_next == '0;
        end
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: self-timed UART transmitter with input byte FIFO and
// configurable data width, parity and stop bits; frames go out back-to-back.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx_framer: illegal parameter value");
    end

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [7:0]      MASK      = 8'((1 << DATA_BITS) - 1);
    localparam logic [CW-1:0]   LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   DONE_CLK  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t     state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift, fifo_data;
    logic          par_bit, fifo_full, fifo_empty, bit_end, last_stop, pop;

    always_comb begin
        bit_end = baud == LAST_CLK;
        last_stop = state == STOP && bit_cnt == LAST_STOP;
        pop = !fifo_empty && (state == IDLE || (last_stop && bit_end));
        in_ready = !fifo_full;
    end

    uart_tx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr_data(in_data),
        .wr_en(in_valid),
        .rd_en(pop),
        .rd_data(fifo_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    // A pop always restarts the frame, both from IDLE and straight out of the last stop bit.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            baud <= '0;
            bit_cnt <= '0;
            shift <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= last_stop && baud == DONE_CLK;
            if (pop) begin
                state <= START;
                baud <= '0;
                bit_cnt <= '0;
                shift <= fifo_data & MASK;
                par_bit <= ^(fifo_data & MASK) ^ (PARITY == PAR_ODD);
                uart_tx <= 1'b0;
                busy <= 1'b1;
            end else if (state != IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
                if (bit_end)
                    case (state)
                        START: begin
                            state <= DATA;
                            uart_tx <= shift[0];
                        end
                        DATA: begin
                            shift <= shift >> 1;
                            bit_cnt <= bit_cnt == LAST_DATA ? '0 : bit_cnt + 1'b1;
                            state <= bit_cnt != LAST_DATA ? DATA : PARITY != PAR_NONE ? PAR : STOP;
                            uart_tx <= bit_cnt != LAST_DATA ? shift[1] : PARITY != PAR_NONE ? par_bit : 1'b1;
                        end
                        PAR: begin
                            state <= STOP;
                            uart_tx <= 1'b1;
                        end
                        default: begin
                            bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                            state <= last_stop ? IDLE : STOP;
                            busy <= !last_stop;
                        end
                    endcase
            end
        end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: four framer configurations (8N1, 7E1, 7O1, 8N2) at 4 clocks per bit,
// each with a per-cycle line monitor fed by a scoreboard of accepted bytes.
module tb_uart_tx_framer;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int N   = 4;
    localparam int DB [N] = '{8, 7, 7, 8};
    localparam int PB [N] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int SB [N] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din   [N];
    logic       valid [N];
    logic       rdy   [N];
    logic       tx    [N];
    logic       busy  [N];
    logic       done  [N];
    logic [2:0] level [N];

    logic [7:0] sb [N][$];
    int run [N];
    int last_run [N];
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        uart_tx_framer #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS(DB[g]),
            .PARITY(PB[g]),
            .STOP_BITS(SB[g]),
            .FIFO_DEPTH(4)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_data(din[g]),
            .in_valid(valid[g]),
            .in_ready(rdy[g]),
            .uart_tx(tx[g]),
            .busy(busy[g]),
            .tx_done(done[g]),
            .fifo_level(level[g])
        );

        always @(posedge clk)
            if (rst_n && valid[g] === 1'b1 && rdy[g] === 1'b1)
                sb[g].push_back(din[g] & 8'((1 << DB[g]) - 1));

        initial begin : mon
            logic [15:0] bits;
            logic [7:0]  b;
            int          fl;
            fl = frame_len(DB[g], PB[g], SB[g]) * CPB;
            forever begin
                @(negedge clk);
                if (rst_n && tx[g] === 1'b0) begin
                    checks++;
                    if (sb[g].size() == 0) begin
                        $display("FAIL u%0d unexpected_frame: got start bit, required idle line (nothing queued)", g);
                        b = '0;
                    end else begin
                        passed++;
                        b = sb[g].pop_front();
                    end
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < DB[g]; i++) bits[1+i] = b[i];
                    if (PB[g] != PAR_NONE) bits[1+DB[g]] = ^b ^ (PB[g] == PAR_ODD);
                    for (int c = 0; c < fl; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!rst_n) break;
                        checks++;
                        if ({tx[g], busy[g], done[g]} !== {bits[c/CPB], 1'b1, c == fl - 1})
                            $display("FAIL u%0d frame byte %02h cycle %0d: tx/busy/done got %b required %b",
                                     g, b, c, {tx[g], busy[g], done[g]}, {bits[c/CPB], 1'b1, c == fl - 1});
                        else passed++;
                    end
                end else if (rst_n) begin
                    checks++;
                    if ({busy[g], done[g]} !== 2'b00)
                        $display("FAIL u%0d idle: busy/done got %b required 00", g, {busy[g], done[g]});
                    else passed++;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (busy[g] === 1'b1) run[g]++;
            else begin
                if (run[g] > 0) last_run[g] = run[g];
                run[g] = 0;
            end
        end
    end

    task automatic send(input int k, input logic [7:0] b, output int waited);
        int n;
        n = 0;
        din[k] = b;
        valid[k] = 1'b1;
        while (rdy[k] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) $display("FAIL send u%0d: in_ready got %b after %0d cycles, required 1", k, rdy[k], n);
        else passed++;
        waited = n;
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((busy[k] !== 1'b0 || level[k] !== 3'd0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) $display("FAIL wait_idle u%0d: busy=%b level=%0d, required idle", k, busy[k], level[k]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) $display("FAIL wait_done u%0d: tx_done got %b, required a pulse", k, done[k]);
        else passed++;
    endtask

    task automatic test_reset;
        for (int k = 0; k < N; k++) begin
            valid[k] = 1'b0;
            din[k] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({tx[k], busy[k], done[k], rdy[k], level[k]} !== 7'b1001_000)
                $display("FAIL reset_hold u%0d: tx/busy/done/ready/level got %b required 1001000", k,
                         {tx[k], busy[k], done[k], rdy[k], level[k]});
            else passed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({tx[k], busy[k], done[k], rdy[k], level[k]} !== 7'b1001_000)
                $display("FAIL reset_release u%0d: tx/busy/done/ready/level got %b required 1001000", k,
                         {tx[k], busy[k], done[k], rdy[k], level[k]});
            else passed++;
        end
    endtask

    task automatic test_8n1;
        int w;
        send(0, 8'hA5, w);
        checks++;
        if ({tx[0], level[0]} !== 4'b1_001)
            $display("FAIL 8n1_accept: tx/level got %b required 1001", {tx[0], level[0]});
        else passed++;
        @(negedge clk);
        checks++;
        if ({tx[0], busy[0], level[0]} !== 5'b01_000)
            $display("FAIL 8n1_start: tx/busy/level got %b required 01000", {tx[0], busy[0], level[0]});
        else passed++;
        wait_idle(0);
        checks++;
        if (last_run[0] !== 40) $display("FAIL 8n1_busy_len: got %0d cycles required 40", last_run[0]);
        else passed++;
    endtask

    task automatic test_parity;
        din[1] = 8'hC1;
        din[2] = 8'h41;
        valid[1] = 1'b1;
        valid[2] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0;
        valid[2] = 1'b0;
        repeat (35) @(negedge clk);
        checks++;
        if (tx[1] !== 1'b0) $display("FAIL even_parity_bit: got %b required 0", tx[1]);
        else passed++;
        checks++;
        if (tx[2] !== 1'b1) $display("FAIL odd_parity_bit: got %b required 1", tx[2]);
        else passed++;
        wait_idle(1);
        wait_idle(2);
        checks++;
        if (last_run[1] !== 40) $display("FAIL 7e1_busy_len: got %0d required 40", last_run[1]);
        else passed++;
        checks++;
        if (last_run[2] !== 40) $display("FAIL 7o1_busy_len: got %0d required 40", last_run[2]);
        else passed++;
    endtask

    task automatic test_stop2;
        int w;
        send(3, 8'h00, w);
        send(3, 8'hFF, w);
        wait_done(3);
        @(negedge clk);
        checks++;
        if ({tx[3], busy[3]} !== 2'b01)
            $display("FAIL stop2_next_start: tx/busy got %b required 01", {tx[3], busy[3]});
        else passed++;
        wait_idle(3);
        checks++;
        if (last_run[3] !== 88) $display("FAIL stop2_busy_len: got %0d required 88", last_run[3]);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                checks++;
                if ({rdy[0], level[0]} !== 4'b0_100)
                    $display("FAIL b2b_full: ready/level got %b required 0100", {rdy[0], level[0]});
                else passed++;
            end
            send(0, 8'(i), w);
            if (i == 6) begin
                checks++;
                if (w !== 37) $display("FAIL b2b_ready_wait: got %0d cycles required 37", w);
                else passed++;
            end
        end
        wait_idle(0);
        checks++;
        if (last_run[0] !== 240) $display("FAIL b2b_busy_len: got %0d required 240", last_run[0]);
        else passed++;
    endtask

    task automatic test_same_edge;
        int w;
        send(0, 8'h11, w);
        send(0, 8'h22, w);
        send(0, 8'h33, w);
        checks++;
        if (level[0] !== 3'd2) $display("FAIL same_edge_pre: level got %0d required 2", level[0]);
        else passed++;
        wait_done(0);
        din[0] = 8'h44;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        checks++;
        if (level[0] !== 3'd2) $display("FAIL same_edge_level: got %0d required 2", level[0]);
        else passed++;
        wait_idle(0);
        checks++;
        if (last_run[0] !== 160) $display("FAIL same_edge_busy_len: got %0d required 160", last_run[0]);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int w;
        send(0, 8'h5A, w);
        send(0, 8'h3C, w);
        send(0, 8'h0F, w);
        repeat (16) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx[0], busy[0], rdy[0], level[0]} !== 6'b101_000)
            $display("FAIL reset_mid: tx/busy/ready/level got %b required 101000", {tx[0], busy[0], rdy[0], level[0]});
        else passed++;
        for (int k = 0; k < N; k++) sb[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if ({tx[0], busy[0], level[0]} !== 5'b10_000)
            $display("FAIL reset_mid_after: tx/busy/level got %b required 10000", {tx[0], busy[0], level[0]});
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_same_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Parametrised UART transmitter that generates its own bit timing, so no external baud generator or bps_start/clk_bps pair is needed. Bytes enter through a valid/ready handshake into an internal FIFO. Each byte is serialised with a configurable data width, parity mode and stop-bit count. It is the next-generation transmit path for sensor read-out (axis bytes, status) to the USB-UART bridge, with back-to-back frames and no software gaps.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (e.g. 50 MHz / 115200); legal >= 2
DATA_BITS, 8, payload bits per frame; legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
in_data  in  8  byte to send; bits above DATA_BITS-1 ignored
in_valid  in  1  in_data valid
in_ready  out  1  FIFO not full; transfer when in_valid & in_ready at rising edge
uart_tx  out  1  serial line, idle high
busy  out  1  FSM not IDLE (frame in progress)
tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit
fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently queued

Behaviour:
- Reset (async, immediate): uart_tx=1, busy=0, tx_done=0, in_ready=1, fifo_level=0; FIFO flushed, FSM to IDLE, bit counter and baud counter cleared.
- Reset asserted mid-frame: line returns high at once. The partial frame is lost and is not resent.
- FIFO: synchronous, registered full/empty. in_ready = !full.
  - Push when in_valid & in_ready.
  - Pop only by the FSM in IDLE, or at the end of STOP when non-empty.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full is impossible by handshake; if in_valid is held, the data is taken once space frees.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every frame start, so each bit lasts exactly CLKS_PER_BIT cycles with zero drift.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a clock edge with FIFO non-empty, pop into the shift register and go to START. uart_tx=0 from that edge.
  - Latency: a byte accepted into an empty FIFO at edge N pops at edge N+1. uart_tx goes low at edge N+1.
  - START: one bit time low, then DATA.
  - DATA: DATA_BITS bit times, LSB first. Shift right at each bit boundary.
  - After DATA: go to PAR if PARITY != 0, else STOP.
  - PAR: even = XOR of payload bits; odd = inverted XOR. Held one bit time.
  - STOP: STOP_BITS*CLKS_PER_BIT cycles high. tx_done pulses on the final cycle.
  - End of STOP: if FIFO non-empty, pop and go straight to START, with no idle cycle between frames. Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy is high from the pop edge until the FSM re-enters IDLE.
- uart_tx is driven from a register (glitch-free). No tri-state or X values on any output after reset.
- Illegal parameter values are rejected at elaboration via generate-time checks.

Decomposition:
- Shared package uart_pkg:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - FSM state encoding
  - helper function frame_len(data_bits, parity, stop_bits)
- Sub-module uart_tx_fifo: parametrised synchronous byte FIFO with level output.
- Framer FSM and baud counter stay in uart_tx_framer.

Test Plan:
- 8N1, CLKS_PER_BIT=4, push 0xA5 into idle block -> uart_tx low one cycle after accept. Line sequence at 4-cycle bits: 0,1,0,1,0,0,1,0,1,1. busy high for 40 cycles. tx_done pulses on cycle 40.
- DATA_BITS=7, PARITY=2 (even), push 0x41 -> data 1,0,0,0,0,0,1, parity 0. Rerun with PARITY=1 (odd) -> parity bit 1. Frame 10 bit times.
- FIFO_DEPTH=4, hold in_valid with 0x01..0x06 -> 5 accepted (one pops immediately). in_ready low with fifo_level=4 until the first frame ends. All 6 frames sent back-to-back with no idle gap.
- STOP_BITS=2, two bytes 0x00, 0xFF -> stop high exactly 2*CLKS_PER_BIT cycles. Second start bit begins on the cycle after the first tx_done.
- Assert rst_n low during DATA bit 3 with 2 bytes queued -> uart_tx=1, busy=0, fifo_level=0, in_ready=1 immediately. After release, no frame is sent.
- Push and pop on the same edge at fifo_level=2 -> fifo_level stays 2. Byte order is preserved on the line.
